// File: rtl/load_store_unit.sv
// load_store_unit: RV32 load/store FSM over a single combinational-read word memory port.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned H/W accesses instead of forcing alignment.
module load_store_unit #(
    parameter int A = 32,
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [2:0]   req_funct3,
    input  logic [A-1:0] req_addr,
    input  logic [N-1:0] req_wdata,
    output logic         resp_valid,
    output logic [N-1:0] resp_rdata,
    output logic         resp_err,
    output logic [A-1:0] mem_addr,
    output logic         mem_we,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata
);
    typedef enum logic [2:0] {IDLE, ACCESS, RMW_RD, WRITE, RESP} state_t;
    state_t state_q, state_d;
    logic [A-1:0] mem_addr_q, mem_addr_d;
    logic [N-1:0] mem_wdata_q, mem_wdata_d, resp_rdata_q, resp_rdata_d;
    logic [2:0] f3_q, f3_d;
    logic [1:0] off_q, off_d;
    logic mem_we_q, mem_we_d, resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
    logic misalign, bad;
    logic [4:0] sh;
    logic [N-1:0] lane, ext, mask, merged;
    always_comb begin
`ifdef LSU_MISALIGN_CHECK_EN
        misalign = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                   (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
        misalign = 1'b0;
`endif
        bad = req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11 || (req_funct3[2] && req_we) || misalign;
        sh = {off_q, 3'b000};
        lane = mem_rdata >> sh;
        ext = f3_q[1] ? mem_rdata :
              f3_q[0] ? {{16{~f3_q[2] & lane[15]}}, lane[15:0]} : {{24{~f3_q[2] & lane[7]}}, lane[7:0]};
        // Sub-word stores replicate the data across lanes, then the mask picks the addressed lane(s).
        mask = (f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
        merged = (mem_rdata & ~mask) | ((f3_q[0] ? {2{mem_wdata_q[15:0]}} : {4{mem_wdata_q[7:0]}}) & mask);
        state_d = state_q;
        mem_addr_d = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        resp_rdata_d = resp_rdata_q;
        f3_d = f3_q;
        off_d = off_q;
        mem_we_d = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d = resp_err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                mem_addr_d = {req_addr[A-1:2], 2'b00};
                mem_wdata_d = req_wdata;
                f3_d = req_funct3;
                off_d = req_funct3[1] ? 2'b00 : req_funct3[0] ? {req_addr[1], 1'b0} : req_addr[1:0];
                if (bad) begin
                    state_d = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d = 1'b1;
                    resp_rdata_d = '0;
                end else if (!req_we) state_d = ACCESS;
                else if (req_funct3[1]) begin
                    state_d = WRITE;
                    mem_we_d = 1'b1;
                end else state_d = RMW_RD;
            end
            ACCESS: begin
                state_d = RESP;
                resp_valid_d = 1'b1;
                resp_err_d = 1'b0;
                resp_rdata_d = ext;
            end
            RMW_RD: begin
                state_d = WRITE;
                mem_we_d = 1'b1;
                mem_wdata_d = merged;
            end
            WRITE: begin
                state_d = RESP;
                resp_valid_d = 1'b1;
                resp_err_d = 1'b0;
                resp_rdata_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mem_addr_q <= '0;
            mem_wdata_q <= '0;
            resp_rdata_q <= '0;
            f3_q <= '0;
            off_q <= '0;
            mem_we_q <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mem_addr_q <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            resp_rdata_q <= resp_rdata_d;
            f3_q <= f3_d;
            off_q <= off_d;
            mem_we_q <= mem_we_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q <= resp_err_d;
        end
    end
    assign req_ready = state_q == IDLE;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err = resp_err_q;
    assign mem_addr = mem_addr_q;
    assign mem_we = mem_we_q;
    assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit against a byte-level model.
module tb_load_store_unit;
    logic clk = 1'b0, rst = 1'b0;
    logic req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [2:0] req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic resp_valid, resp_err, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic ld_en = 1'b0;
    logic [5:0] ld_idx = '0;
    logic [31:0] ld_data = '0;
    logic [31:0] obs_rdata, obs_wd;
    logic obs_err;
    int errors = 0, checks = 0;

    load_store_unit #(.A(32), .N(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (ld_en) mem[ld_idx] <= ld_data;
        else if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    end

    // Reference: expected result of one request from the architectural byte-lane rules.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [7:0] a,
                                  input logic [31:0] wd, output logic bad, output int lat,
                                  output logic [31:0] rd, output logic [31:0] nw);
        int size, off;
        logic [31:0] word, m;
        word = ref_mem[a[7:2]];
        size = int'(f3[1:0]);
        bad = (f3 == 3'd3) || (f3 >= 3'd6) || (we && f3 >= 3'd4);
`ifdef LSU_MISALIGN_CHECK_EN
        if ((size == 1 && a[0]) || (size == 2 && a[1:0] != 2'b00)) bad = 1'b1;
`endif
        off = size == 2 ? 0 : size == 1 ? int'(a[1:0] & 2'b10) : int'(a[1:0]);
        rd = '0;
        nw = word;
        lat = 1;
        if (bad) lat = 1;
        else if (!we) begin
            lat = 2;
            m = size == 2 ? 32'hFFFF_FFFF : size == 1 ? 32'h0000_FFFF : 32'h0000_00FF;
            rd = (word >> (8 * off)) & m;
            if (!f3[2] && size != 2 && rd[size == 1 ? 15 : 7]) rd = rd | ~m;
        end else begin
            lat = size == 2 ? 2 : 3;
            for (int i = 0; i < (1 << size); i++) nw[8 * (off + i) +: 8] = wd[8 * i +: 8];
        end
    endfunction

    task automatic preload(input int idx, input logic [31:0] d);
        ld_en = 1'b1;
        ld_idx = 6'(idx);
        ld_data = d;
        @(posedge clk);
        #1 ld_en = 1'b0;
        ref_mem[idx] = d;
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [7:0] a, input logic [31:0] wd);
        logic bad;
        int lat, resp_n, resp_at, we_n, we_at;
        logic [31:0] exp_rd, exp_wd, got_rd, got_wd, got_wa;
        logic got_err;
        model(we, f3, a, wd, bad, lat, exp_rd, exp_wd);
        resp_n = 0; resp_at = 0; we_n = 0; we_at = 0;
        got_rd = '0; got_wd = '0; got_wa = '0; got_err = 1'b0;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = {24'h0, a}; req_wdata = wd;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_idle got=%b want=1", req_ready); end
        @(posedge clk);
        #1;
        req_we = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (mem_we) begin we_n++; we_at = k; got_wd = mem_wdata; got_wa = mem_addr; end
            if (resp_valid) begin resp_n++; resp_at = k; got_rd = resp_rdata; got_err = resp_err; req_valid = 1'b0; end
        end
        req_valid = 1'b0;
        checks++;
        if (resp_n != 1 || resp_at != lat) begin
            errors++; $display("FAIL resp_timing we=%b f3=%0d a=%h got n=%0d at=%0d want n=1 at=%0d", we, f3, a, resp_n, resp_at, lat);
        end
        checks++;
        if (got_err !== bad) begin errors++; $display("FAIL resp_err f3=%0d a=%h got=%b want=%b", f3, a, got_err, bad); end
        checks++;
        if (got_rd !== exp_rd) begin errors++; $display("FAIL resp_rdata f3=%0d a=%h got=%h want=%h", f3, a, got_rd, exp_rd); end
        checks++;
        if (resp_rdata !== got_rd || resp_err !== got_err) begin
            errors++; $display("FAIL resp_hold got=%h/%b want=%h/%b", resp_rdata, resp_err, got_rd, got_err);
        end
        checks++;
        if (we_n != ((we && !bad) ? 1 : 0)) begin errors++; $display("FAIL we_count f3=%0d a=%h got=%0d want=%0d", f3, a, we_n, (we && !bad) ? 1 : 0); end
        if (we && !bad) begin
            checks++;
            if (we_at != lat - 1) begin errors++; $display("FAIL we_cycle got=%0d want=%0d", we_at, lat - 1); end
            checks++;
            if (got_wd !== exp_wd || got_wa !== {24'h0, a[7:2], 2'b00}) begin
                errors++; $display("FAIL wdata f3=%0d a=%h got=%h@%h want=%h@%h", f3, a, got_wd, got_wa, exp_wd, {24'h0, a[7:2], 2'b00});
            end
            ref_mem[a[7:2]] = exp_wd;
        end
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after got=%b want=1", req_ready); end
        obs_rdata = got_rd; obs_err = got_err; obs_wd = got_wd;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0 ||
            mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b rv=%b err=%b rd=%h we=%b ma=%h wd=%h want 1 0 0 0 0 0 0",
                     req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_addr, mem_wdata);
        end
        for (int i = 0; i < 64; i++) preload(i, $urandom);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        preload(4, 32'h80FF_7F01);
        preload(8, 32'h1122_3344);
        @(negedge clk);
        do_req(1'b1, 3'b010, 8'h10, 32'hDEAD_BEEF);
        checks++;
        if (obs_wd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_data got=%h want=deadbeef", obs_wd); end
        do_req(1'b1, 3'b010, 8'h10, 32'h80FF_7F01);
        do_req(1'b0, 3'b000, 8'h12, 32'h0);
        checks++;
        if (obs_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL lb got=%h want=ffffffff", obs_rdata); end
        do_req(1'b0, 3'b100, 8'h12, 32'h0);
        checks++;
        if (obs_rdata !== 32'h0000_00FF) begin errors++; $display("FAIL lbu got=%h want=000000ff", obs_rdata); end
        do_req(1'b0, 3'b001, 8'h12, 32'h0);
        checks++;
        if (obs_rdata !== 32'hFFFF_80FF) begin errors++; $display("FAIL lh got=%h want=ffff80ff", obs_rdata); end
        do_req(1'b1, 3'b000, 8'h21, 32'h0000_00AA);
        checks++;
        if (obs_wd !== 32'h1122_AA44) begin errors++; $display("FAIL sb_merge got=%h want=1122aa44", obs_wd); end
        do_req(1'b0, 3'b010, 8'h22, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
        checks++;
        if (obs_err !== 1'b1) begin errors++; $display("FAIL lw_misaligned got=%b want=1", obs_err); end
`else
        checks++;
        if (obs_rdata !== 32'h1122_AA44 || obs_err !== 1'b0) begin errors++; $display("FAIL lw_forced got=%h/%b want=1122aa44/0", obs_rdata, obs_err); end
`endif
    endtask

    task automatic test_illegal();
        do_req(1'b0, 3'b011, 8'h40, 32'h0);
        do_req(1'b1, 3'b110, 8'h44, 32'h1234_5678);
        do_req(1'b0, 3'b111, 8'h48, 32'h0);
        do_req(1'b1, 3'b100, 8'h4C, 32'hFFFF_FFFF);
        do_req(1'b1, 3'b101, 8'h50, 32'hFFFF_FFFF);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) do_req(1'($urandom), 3'($urandom_range(0, 7)), 8'($urandom), $urandom);
    endtask

    task automatic test_back_to_back();
        logic bad;
        int lat, k1, k2;
        logic [31:0] e1, e2, nw, r1, r2;
        logic [7:0] a1, a2;
        a1 = 8'($urandom); a2 = 8'($urandom);
        model(1'b0, 3'b100, a1, 32'h0, bad, lat, e1, nw);
        model(1'b0, 3'b000, a2, 32'h0, bad, lat, e2, nw);
        k1 = 0; k2 = 0; r1 = '0; r2 = '0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b100; req_addr = {24'h0, a1};
        @(posedge clk);
        #1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k1 != 0 && k == k1 + 2) req_valid = 1'b0;
            if (resp_valid && k1 == 0) begin
                k1 = k; r1 = resp_rdata;
                req_funct3 = 3'b000; req_addr = {24'h0, a2};
            end else if (resp_valid && k2 == 0) begin
                k2 = k; r2 = resp_rdata;
            end
        end
        req_valid = 1'b0;
        checks++;
        if (k1 != 2 || k2 - k1 != 3) begin errors++; $display("FAIL b2b_timing got k1=%0d gap=%0d want 2 and 3", k1, k2 - k1); end
        checks++;
        if (r1 !== e1 || r2 !== e2) begin errors++; $display("FAIL b2b_data got=%h,%h want=%h,%h", r1, r2, e1, e2); end
    endtask

    task automatic test_reset_mid();
        logic found;
        int rv;
        found = 1'b0; rv = 0;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h32; req_wdata = $urandom;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 4 && !found; k++) begin
            @(negedge clk);
            if (mem_we) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rst_mid_write got no mem_we want pulse"); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++; $display("FAIL rst_async got we=%b rv=%b rdy=%b ma=%h wd=%h want 0 0 1 0 0", mem_we, resp_valid, req_ready, mem_addr, mem_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp_valid) rv++;
        end
        checks++;
        if (rv != 0 || mem[12] !== ref_mem[12]) begin
            errors++; $display("FAIL rst_abort got resp=%0d word=%h want resp=0 word=%h", rv, mem[12], ref_mem[12]);
        end
        do_req(1'b0, 3'b010, 8'h30, 32'h0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter A, default 32, address width.
REQ-002 Parameter N, default 32, data width; only 32 is supported.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 req_valid  input  1  core request present.
REQ-006 req_ready  output  1  unit can accept a request.
REQ-007 req_we  input  1  1=store, 0=load.
REQ-008 req_funct3  input  3  RISC-V size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 req_addr  input  A  byte address.
REQ-010 req_wdata  input  N  store data, right-justified.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  N  extended load data; 0 for stores and errors.
REQ-013 resp_err  output  1  request rejected; qualified by resp_valid.
REQ-014 mem_addr  output  A  word-aligned memory address, {addr[A-1:2],2'b00}.
REQ-015 mem_we  output  1  memory write enable; memory always writes 4 bytes.
REQ-016 mem_wdata  output  N  full word to write.
REQ-017 mem_rdata  input  N  combinational read of the word at mem_addr.

Function
REQ-018 The unit SHALL be an FSM with states IDLE, ACCESS, RMW_RD, WRITE and RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle with req_valid=1 in IDLE (cycle T).
REQ-020 On acceptance, mem_addr, the byte offset, funct3, we and wdata SHALL be registered; mem_* outputs SHALL be driven only from registers.
REQ-021 Load: IDLE->ACCESS (T+1, mem_rdata sampled) ->RESP (T+2, resp_valid=1) ->IDLE.
REQ-022 Load extraction: the byte or halfword at offset addr[1:0] is selected; B/H are sign-extended and BU/HU zero-extended; W is passed unchanged.
REQ-023 SW: IDLE->WRITE (T+1, mem_we=1, mem_wdata=req_wdata) ->RESP (T+2).
REQ-024 SB/SH: IDLE->RMW_RD (T+1, word captured) ->WRITE (T+2, mem_we=1, merged word) ->RESP (T+3).
REQ-025 The merged word SHALL replace only the addressed byte lane(s) with the low 8/16 bits of wdata; all other lanes keep the read value.
REQ-026 mem_we SHALL be 1 for exactly one cycle per store and 0 in every other state.
REQ-027 An illegal code (011, 11x, or 100/101 with we=1) SHALL go IDLE->RESP at T+1 with resp_err=1 and no memory write.
REQ-028 resp_valid SHALL be a single-cycle pulse with no backpressure; resp_rdata and resp_err are held until the next RESP.
REQ-029 req_valid outside IDLE SHALL be ignored; the requester holds it until it sees ready.
REQ-030 Back-to-back operation: the cycle after RESP is IDLE and can accept a new request, so a load costs 3 cycles per request.

Reset
REQ-031 rst SHALL force IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0 and mem_wdata=0 immediately, independent of clk.
REQ-032 Reset asserted mid-operation (including in WRITE) SHALL abort the operation with no response and no further write.

Configuration
REQ-033 Macro LSU_MISALIGN_CHECK_EN defined: H/HU with addr[0]=1 or W with addr[1:0]!=0 go to RESP at T+1 with resp_err=1 and no memory access.
REQ-034 Macro not defined: alignment is forced (H uses offset {addr[1],0}, W uses offset 0) and resp_err is raised only by REQ-027.

Verification
REQ-035 SW addr 0x10, data 0xDEADBEEF -> T+1 mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF; T+2 resp_valid=1, err=0.
REQ-036 Memory word at 0x10 = 0x80FF7F01 -> LB addr 0x12 returns 0xFFFFFFFF; LBU addr 0x12 returns 0x000000FF; LH addr 0x12 returns 0xFFFF80FF; each at T+2.
REQ-037 Word at 0x20 = 0x11223344; SB addr 0x21, data 0xAA -> T+2 mem_wdata=0x1122AA44, single mem_we pulse, resp at T+3.
REQ-038 LW addr 0x22: with LSU_MISALIGN_CHECK_EN -> resp at T+1, err=1, no access; without it -> word at 0x20 returned at T+2, err=0.
REQ-039 Async rst pulse during WRITE of SH -> mem_we drops immediately, no resp_valid, next request accepted normally.
